// File: rtl/onchip_memory_pipelined.sv
// onchip_memory_pipelined: single-port on-chip RAM with byte-enable writes
// and a pipelined registered read path (READ_LATENCY of 1 or 2).
// Optional per-byte even parity is compiled in with the macro
// ONCHIP_MEMORY_PIPELINED_PARITY_EN (adds parity_clear / parity_error ports).
module onchip_memory_pipelined #(
    parameter int    DATA_WIDTH   = 32,
    parameter int    ADDR_WIDTH   = 13,
    parameter int    READ_LATENCY = 2,
    parameter string INIT_FILE    = "onchip_memory_pipelined.hex"
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    reset_req,
    input  logic                    clken,
    input  logic                    chipselect,
    input  logic                    read,
    input  logic                    write,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH/8-1:0] byteenable,
    input  logic [DATA_WIDTH-1:0]   writedata,
`ifdef ONCHIP_MEMORY_PIPELINED_PARITY_EN
    input  logic                    parity_clear,
    output logic                    parity_error,
`endif
    output logic                    waitrequest,
    output logic [DATA_WIDTH-1:0]   readdata,
    output logic                    readdatavalid
);

    localparam int NUM_LANES = DATA_WIDTH / 8;
    localparam int DEPTH     = 1 << ADDR_WIDTH;

    // Reject unsupported configurations at elaboration time.
    generate
        if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
            $error("onchip_memory_pipelined: READ_LATENCY must be 1 or 2");
        end
        if (DATA_WIDTH % 8 != 0 || DATA_WIDTH < 8 || DATA_WIDTH > 128) begin : g_bad_width
            $error("onchip_memory_pipelined: DATA_WIDTH must be a multiple of 8 in 8..128");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    logic                  wr_accept;
    logic                  rd_accept;
    logic                  final_load;
    logic [DATA_WIDTH-1:0] final_data;
    logic [DATA_WIDTH-1:0] readdata_reg;
    logic                  readdatavalid_reg;

    // Stall whenever the block is frozen, resetting, or about to reset.
    assign waitrequest = ~clken | reset_req | reset;
    // A simultaneous read+write is treated as a write only.
    assign wr_accept   = chipselect & write & ~waitrequest;
    assign rd_accept   = chipselect & read & ~write & ~waitrequest;

    // Byte-lane write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (byteenable[i]) begin
                    mem[address][i*8 +: 8] <= writedata[i*8 +: 8];
                end
            end
        end
    end

`ifdef ONCHIP_MEMORY_PIPELINED_PARITY_EN
    logic [NUM_LANES-1:0] par_mem [0:DEPTH-1];
    logic [NUM_LANES-1:0] wr_par;
    logic [NUM_LANES-1:0] final_par;
    logic [NUM_LANES-1:0] lane_mismatch;
    logic                 parity_error_reg;

    // Even parity per lane on write, and per-lane check on the returning word.
    generate
        for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_par_lane
            assign wr_par[gi]        = ^writedata[gi*8 +: 8];
            assign lane_mismatch[gi] = (^final_data[gi*8 +: 8]) != final_par[gi];
        end
    endgenerate

    // Parity bits are written under the same byte enables as the data.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (byteenable[i]) begin
                    par_mem[address][i] <= wr_par[i];
                end
            end
        end
    end

    // Sticky error flag, raised on the edge that presents the bad word; set beats clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            parity_error_reg <= 1'b0;
        end else if (clken) begin
            if (final_load && (|lane_mismatch)) begin
                parity_error_reg <= 1'b1;
            end else if (parity_clear) begin
                parity_error_reg <= 1'b0;
            end
        end
    end

    assign parity_error = parity_error_reg;
`endif

    // Read pipeline: latency 2 adds a RAM output register ahead of readdata.
    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic [DATA_WIDTH-1:0] ram_q_reg;
            logic                  rd_pending_reg;
`ifdef ONCHIP_MEMORY_PIPELINED_PARITY_EN
            logic [NUM_LANES-1:0]  ram_par_reg;

            // Parity travels alongside the data through the RAM output stage.
            always_ff @(posedge clk) begin
                if (rd_accept) begin
                    ram_par_reg <= par_mem[address];
                end
            end

            assign final_par = ram_par_reg;
`endif

            // Synchronous RAM read, captured only for accepted reads.
            always_ff @(posedge clk) begin
                if (rd_accept) begin
                    ram_q_reg <= mem[address];
                end
            end

            // Tracks a read sitting in the RAM output stage; frozen by clken, dropped by reset.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_pending_reg <= 1'b0;
                end else if (clken) begin
                    rd_pending_reg <= rd_accept;
                end
            end

            assign final_load = clken & rd_pending_reg;
            assign final_data = ram_q_reg;
        end else begin : g_lat1
            assign final_load = rd_accept;
            assign final_data = mem[address];
`ifdef ONCHIP_MEMORY_PIPELINED_PARITY_EN
            assign final_par  = par_mem[address];
`endif
        end
    endgenerate

    // Output data register: loads only on a returning read, otherwise holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata_reg <= '0;
        end else if (final_load) begin
            readdata_reg <= final_data;
        end
    end

    // One-cycle valid qualifier, held while the clock enable is low.
    always_ff @(posedge clk) begin
        if (reset) begin
            readdatavalid_reg <= 1'b0;
        end else if (clken) begin
            readdatavalid_reg <= final_load;
        end
    end

    assign readdata      = readdata_reg;
    assign readdatavalid = readdatavalid_reg;

endmodule
